// File: rtl/medidor_pkg.sv
// -----------------------------------------------------------------------------
// medidor_pkg
// Shared definitions for the InClk period meter.
//   CNT_W_DEF : default width of the cycle counter and of the result registers
//   estado_t  : two-bit FSM state encoding used by medidor_de_periodo
// -----------------------------------------------------------------------------
package medidor_pkg;

    localparam int CNT_W_DEF = 16;

    // IDLE      : disarmed, waiting for Enable
    // ARM       : armed, waiting for the rise that opens a measurement
    // MEDIR     : counting Clk cycles until the next rise
    // PRESENTAR : result on the outputs, waiting for the consumer
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        MEDIR     = 2'd2,
        PRESENTAR = 2'd3
    } estado_t;

endpackage

// File: rtl/sincronizador_flanco.sv
// -----------------------------------------------------------------------------
// sincronizador_flanco
// Brings an asynchronous level into the clk domain through a flop chain and
// turns its transitions into single-cycle pulses.
//   clk      : system clock
//   reset    : asynchronous, active-low reset (clears every flop)
//   in_asinc : asynchronous input level
//   subida   : one-cycle pulse after a synchronised 0->1 transition
//   bajada   : one-cycle pulse after a synchronised 1->0 transition
// The pulses are decoded from the last synchroniser stage and the edge flop,
// so a consumer registering them acts on the third clk edge after the input
// transition.
// -----------------------------------------------------------------------------
module sincronizador_flanco #(
    parameter int ETAPAS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_asinc,
    output logic subida,
    output logic bajada
);

    logic [ETAPAS-1:0] sync_reg;
    logic              flanco_reg;
    logic              nivel;

    // The first stage may go metastable; only the last stage is used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[ETAPAS-2:0], in_asinc};
        end
    end

    assign nivel = sync_reg[ETAPAS-1];

    // Previous synchronised level, for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flanco_reg <= 1'b0;
        end else begin
            flanco_reg <= nivel;
        end
    end

    assign subida = nivel & ~flanco_reg;
    assign bajada = ~nivel & flanco_reg;

endmodule

// File: rtl/medidor_de_periodo.sv
// -----------------------------------------------------------------------------
// medidor_de_periodo
// Measures the period and the high time of a slow clock (InClk) in units of
// the system clock Clk, one rise-to-rise interval at a time.
//   Clk      : system clock, all state changes on its rising edge
//   reset    : asynchronous, active-low reset
//   InClk    : clock to be measured, asynchronous to Clk
//   Enable   : arms measurement while high
//   Periodo  : last measured period, in Clk cycles
//   HighTime : last measured high time, in Clk cycles
//   Valid    : a result is being presented
//   Ready    : consumer accepts the presented result
//   Timeout  : one-cycle pulse when no closing rise arrived within the
//              counter range
// Each accepted result belongs to a single interval; the closing rise of one
// measurement is never reused as the opening rise of the next.
// -----------------------------------------------------------------------------
module medidor_de_periodo
    import medidor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             InClk,
    input  logic             Enable,
    output logic [CNT_W-1:0] Periodo,
    output logic [CNT_W-1:0] HighTime,
    output logic             Valid,
    input  logic             Ready,
    output logic             Timeout
);

    localparam logic [CNT_W-1:0] CNT_UNO = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // Edge pulses from the synchronised InClk
    // -------------------------------------------------------------------------
    logic subida;
    logic bajada;

    sincronizador_flanco #(
        .ETAPAS (2)
    ) u_sincronizador (
        .clk      (Clk),
        .reset    (reset),
        .in_asinc (InClk),
        .subida   (subida),
        .bajada   (bajada)
    );

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    estado_t          state_reg;
    estado_t          state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] alto_pend_reg;   // high time of the interval in progress
    logic [CNT_W-1:0] periodo_reg;
    logic [CNT_W-1:0] alto_reg;
    logic             timeout_reg;

    // Datapath controls decoded from the state
    logic cnt_cargar;
    logic cnt_incr;
    logic alto_capturar;
    logic resultado_cargar;
    logic timeout_set;
    logic valid_c;

    logic cnt_lleno;
    assign cnt_lleno = (cnt_reg == CNT_MAX);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // Enable low wins over any edge or count condition while armed or
    // counting. In PRESENTAR only the handshake can move the state, so a
    // dropped Enable never loses a finished result.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (Enable) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (!Enable) begin
                    state_next = IDLE;
                end else if (subida) begin
                    state_next = MEDIR;
                end
            end
            MEDIR: begin
                if (!Enable) begin
                    state_next = IDLE;
                end else if (subida) begin
                    state_next = PRESENTAR;
                end else if (cnt_lleno) begin
                    state_next = ARM;
                end
            end
            PRESENTAR: begin
                if (Ready) begin
                    state_next = Enable ? ARM : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / control decode
    // A closing rise and a full counter in the same cycle count as a valid
    // measurement of 2^CNT_W-1 cycles, not as a timeout.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_cargar       = 1'b0;
        cnt_incr         = 1'b0;
        alto_capturar    = 1'b0;
        resultado_cargar = 1'b0;
        timeout_set      = 1'b0;
        valid_c          = 1'b0;
        unique case (state_reg)
            ARM: begin
                cnt_cargar = Enable & subida;
            end
            MEDIR: begin
                if (Enable) begin
                    alto_capturar    = bajada;
                    resultado_cargar = subida;
                    cnt_incr         = ~subida & ~cnt_lleno;
                    timeout_set      = ~subida & cnt_lleno;
                end
            end
            PRESENTAR: begin
                valid_c = 1'b1;
            end
            default: begin
                valid_c = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Cycle counter
    // Loaded with 1 on the opening rise so that, on the closing rise N cycles
    // later, it holds exactly N.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (cnt_cargar) begin
            cnt_reg <= CNT_UNO;
        end else if (cnt_incr) begin
            cnt_reg <= cnt_reg + CNT_UNO;
        end
    end

    // -------------------------------------------------------------------------
    // Pending high time
    // The fall is captured here rather than straight into HighTime so that an
    // aborted or timed-out interval leaves the visible outputs untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            alto_pend_reg <= '0;
        end else if (cnt_cargar) begin
            alto_pend_reg <= '0;
        end else if (alto_capturar) begin
            alto_pend_reg <= cnt_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Result registers, committed together on the closing rise
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            periodo_reg <= '0;
            alto_reg    <= '0;
        end else if (resultado_cargar) begin
            periodo_reg <= cnt_reg;
            alto_reg    <= alto_pend_reg;
        end
    end

    // Timeout pulse coincides with the return to ARM.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_set;
        end
    end

    assign Periodo  = periodo_reg;
    assign HighTime = alto_reg;
    assign Valid    = valid_c;
    assign Timeout  = timeout_reg;

endmodule

// File: tb/tb_medidor_de_periodo.sv
// -----------------------------------------------------------------------------
// tb_medidor_de_periodo
// Scoreboard bench for medidor_de_periodo (CNT_W = 8). Stimulus tasks build
// InClk waveforms interval by interval and push the (period, high) pair of
// every interval that must be reported; a negedge monitor compares whatever
// the DUT presents against the head of the queue and pops on handshake.
// -----------------------------------------------------------------------------
module tb_medidor_de_periodo;
    import medidor_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_clk = 1'b0;
    logic         enable = 1'b0;
    logic         ready = 1'b1;
    logic [W-1:0] periodo;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    always #5 clk = ~clk;

    medidor_de_periodo #(
        .CNT_W (W)
    ) dut (
        .Clk      (clk),
        .reset    (reset_n),
        .InClk    (in_clk),
        .Enable   (enable),
        .Periodo  (periodo),
        .HighTime (high_time),
        .Valid    (valid),
        .Ready    (ready),
        .Timeout  (timeout)
    );

    typedef struct {
        int p;
        int h;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_push = 0;
    int   n_hs = 0;
    int   n_tmo_cycles = 0;
    int   exp_tmo = 0;
    int   last_p = 0;
    int   last_h = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (timeout) begin
                n_tmo_cycles++;
                $display("TIMEOUT pulse t=%0t", $time);
            end
            if (valid) begin
                check("valid_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("periodo", int'(periodo), exp_q[0].p);
                    check("hightime", int'(high_time), exp_q[0].h);
                    if (ready) begin
                        $display("RESULT periodo=%0d hightime=%0d exp=%0d/%0d t=%0t",
                                 periodo, high_time, exp_q[0].p, exp_q[0].h, $time);
                        void'(exp_q.pop_front());
                        n_hs++;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_exp(int p, int h);
        res_t r;
        r.p = p;
        r.h = h;
        exp_q.push_back(r);
        n_push++;
        last_p = p;
        last_h = h;
    endtask

    task automatic wait_valid(string name);
        int t;
        t = 0;
        while (!valid && t < 60) begin
            tick();
            t++;
        end
        check(name, int'(valid), 1);
    endtask

    // k back-to-back intervals (k odd) starting with the DUT armed and InClk
    // low. The closing rise of a reported interval cannot open the next one,
    // so with Ready high only the even-numbered intervals are reported.
    // fixed_n == 0 selects random periods.
    task automatic run_phase(int k, int fixed_n, int fixed_h);
        int n;
        int h;
        for (int i = 0; i < k; i++) begin
            if (fixed_n == 0) begin
                n = int'($urandom_range(60, 4));
                h = int'($urandom_range(n - 2, 2));
            end else begin
                n = fixed_n;
                h = fixed_h;
            end
            if (i % 2 == 0) begin
                push_exp(n, h);
            end
            in_clk = 1'b1;
            tick(h);
            in_clk = 1'b0;
            tick(n - h);
        end
        in_clk = 1'b1;
        tick(3);
        in_clk = 1'b0;
        tick(20);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int tmo_before;

        #12;
        check("rst_periodo", int'(periodo), 0);
        check("rst_hightime", int'(high_time), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_state", int'(dut.state_reg), int'(IDLE));
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("idle_valid", int'(valid), 0);
        enable = 1'b1;
        tick(5);

        // Divide-by-10, 50 % duty
        run_phase(7, 10, 5);
        // 6-cycle period, 2 high / 4 low
        run_phase(5, 6, 2);
        // Random periods
        repeat (3) run_phase(9, 0, 0);

        // Consumer stalls for 100 cycles while InClk keeps toggling
        ready = 1'b0;
        push_exp(12, 7);
        in_clk = 1'b1; tick(7);
        in_clk = 1'b0; tick(5);
        in_clk = 1'b1; tick(4);
        in_clk = 1'b0;
        wait_valid("hold_valid_seen");
        for (int c = 0; c < 100; c++) begin
            in_clk = ((c % 8) < 4);
            tick();
        end
        in_clk = 1'b0;
        tick(6);
        check("hold_valid_kept", int'(valid), 1);
        ready = 1'b1;
        tick(3);
        check("hold_valid_dropped", int'(valid), 0);
        run_phase(3, 9, 4);

        // Enable dropped mid-measurement: partial count discarded
        in_clk = 1'b1;
        tick(6);
        enable = 1'b0;
        tick(2);
        check("endrop_state", int'(dut.state_reg), int'(IDLE));
        check("endrop_valid", int'(valid), 0);
        check("endrop_periodo", int'(periodo), last_p);
        check("endrop_hightime", int'(high_time), last_h);
        in_clk = 1'b0; tick(5);
        in_clk = 1'b1; tick(3);
        in_clk = 1'b0; tick(5);
        enable = 1'b1;
        tick(5);

        // Enable dropped while presenting: result held until Ready
        ready = 1'b0;
        push_exp(8, 3);
        in_clk = 1'b1; tick(3);
        in_clk = 1'b0; tick(5);
        in_clk = 1'b1;
        wait_valid("pres_valid_seen");
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_clk = ((c % 6) < 3);
            tick();
        end
        in_clk = 1'b0;
        tick(6);
        check("pres_valid_kept", int'(valid), 1);
        ready = 1'b1;
        tick(2);
        check("pres_valid_dropped", int'(valid), 0);
        check("pres_state_idle", int'(dut.state_reg), int'(IDLE));
        enable = 1'b1;
        tick(5);

        // Timeout: InClk stuck high after one rise
        tmo_before = n_tmo_cycles;
        exp_tmo++;
        in_clk = 1'b1;
        tick(250);
        check("tmo_not_early", n_tmo_cycles - tmo_before, 0);
        tick(50);
        check("tmo_once", n_tmo_cycles - tmo_before, 1);
        check("tmo_state_arm", int'(dut.state_reg), int'(ARM));
        check("tmo_valid", int'(valid), 0);
        check("tmo_periodo", int'(periodo), last_p);
        check("tmo_hightime", int'(high_time), last_h);
        in_clk = 1'b0;
        tick(10);

        // Asynchronous reset in the middle of a measurement
        in_clk = 1'b1; tick(4);
        in_clk = 1'b0; tick(3);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_periodo", int'(periodo), 0);
        check("arst_hightime", int'(high_time), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_timeout", int'(timeout), 0);
        check("arst_state", int'(dut.state_reg), int'(IDLE));
        last_p = 0;
        last_h = 0;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        run_phase(3, 10, 4);

        tick(20);
        check("queue_empty", exp_q.size(), 0);
        check("handshakes", n_hs, n_push);
        check("timeouts", n_tmo_cycles, exp_tmo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/medidor_de_periodo.md
MEDIDOR_DE_PERIODO -- requirements
Module: medidor_de_periodo

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the counter and result width in bits.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port InClk, input, 1 bit: divided clock to be measured, asynchronous to Clk.
REQ-005 The block SHALL have port Enable, input, 1 bit: arms measurement while high.
REQ-006 The block SHALL have port Periodo, output, CNT_W bits: measured InClk period in Clk cycles.
REQ-007 The block SHALL have port HighTime, output, CNT_W bits: measured InClk high time in Clk cycles.
REQ-008 The block SHALL have port Valid, output, 1 bit: result available.
REQ-009 The block SHALL have port Ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port Timeout, output, 1 bit: one-cycle pulse, no rising edge seen within counter range.

Function
REQ-011 InClk SHALL pass through a two-flop synchronizer, then a one-flop edge detector, giving rise/fall pulses 3 Clk edges after the InClk transition.
REQ-012 InClk high and low phases SHALL each be at least 2 Clk cycles; narrower phases give undefined results.
REQ-013 The FSM SHALL have states IDLE, ARM, MEDIR and PRESENTAR.
REQ-014 IDLE SHALL go to ARM when Enable=1.
REQ-015 ARM SHALL go to MEDIR on a rise pulse and SHALL load the counter with 1 in that cycle.
REQ-016 In MEDIR the counter SHALL increment by 1 per cycle.
REQ-017 In MEDIR a fall pulse SHALL load HighTime with the current counter value.
REQ-018 In MEDIR a rise pulse SHALL load Periodo with the current counter value and go to PRESENTAR.
REQ-019 For an InClk period of N Clk cycles with H high cycles, the result SHALL be Periodo=N and HighTime=H exactly.
REQ-020 In MEDIR, a counter value of 2^CNT_W-1 with no rise pulse SHALL assert Timeout for one cycle, go to ARM, and leave Periodo/HighTime unchanged.
REQ-021 In PRESENTAR, Valid SHALL be 1 and Periodo/HighTime SHALL be held stable.
REQ-022 In PRESENTAR, Valid&Ready SHALL deassert Valid the next cycle and go to ARM if Enable=1, else to IDLE.
REQ-023 InClk edges during PRESENTAR SHALL be ignored; the next measurement SHALL start on the first rise after leaving PRESENTAR, so measurements never overlap.
REQ-024 Enable=0 in ARM or MEDIR SHALL go to IDLE next cycle, discard the partial count, and leave outputs unchanged.
REQ-025 Enable=0 in PRESENTAR SHALL NOT drop Valid; the result SHALL be held until Ready.
REQ-026 Valid SHALL be asserted 1 cycle after the terminating rise pulse.

Reset
REQ-027 On reset=0, the block SHALL asynchronously clear the state to IDLE and set Periodo=0, HighTime=0, Valid=0, Timeout=0, counter=0, and synchronizer/edge flops=0.
REQ-028 Reset asserted mid-measurement or mid-handshake SHALL abort with no partial result and no Timeout pulse.
REQ-029 After reset release, the first measurement SHALL require a full rise-to-rise interval.

Structure
REQ-030 Shared package medidor_pkg SHALL hold the FSM state encoding (2 bits) and the default CNT_W constant.
REQ-031 Sub-module sincronizador_flanco SHALL contain the 2-flop synchronizer plus edge detector and output rise/fall pulses; the top SHALL contain only the FSM, counter and result registers.

Verification
REQ-032 The bench SHALL apply InClk from a divide-by-10 divider, 50% duty, Enable=1, Ready=1, and require Periodo=10, HighTime=5, with Valid pulsed once per accepted result.
REQ-033 The bench SHALL apply an InClk period of 6 cycles with 2 high / 4 low, and require Periodo=6, HighTime=2.
REQ-034 The bench SHALL hold Ready=0 for 100 cycles after Valid, and require Valid to stay 1 with outputs stable and intervening edges ignored; after Ready=1, the next result SHALL be a fresh full period.
REQ-035 With CNT_W=8, the bench SHALL hold InClk high after one rise, and require exactly one Timeout pulse when the counter reaches 255, followed by state ARM with Valid=0.
REQ-036 The bench SHALL assert reset=0 mid-MEDIR, and require all outputs 0 immediately (asynchronous) and no Valid until a complete new period is measured.
REQ-037 The bench SHALL drop Enable mid-MEDIR, then during PRESENTAR: in the first case the result SHALL be discarded and the state SHALL be IDLE; in the second, Valid SHALL be held until Ready and the block SHALL then go to IDLE.
